// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//    Shares a single main-memory port between the instruction cache and the
//    data cache. One requester is granted per transaction. When both request
//    at once, the one that was not served last wins (round-robin). Returned
//    read blocks are registered per cache. The BUSYWAIT outputs stall the
//    caches, and through them the PC register.
//
// Ports
//    CLK, RESET                  clock, synchronous active-high reset
//    I_READ, I_ADDRESS           I-cache read request and block address
//    I_READDATA, I_BUSYWAIT      registered I-cache block, I-cache stall
//    D_READ, D_WRITE             D-cache read/write request (write wins if both)
//    D_ADDRESS, D_WRITEDATA      D-cache block address and write block
//    D_READDATA, D_BUSYWAIT      registered D-cache block, D-cache stall
//    MEM_READ, MEM_WRITE         memory strobes
//    MEM_ADDRESS, MEM_WRITEDATA  memory block address and write block
//    MEM_READDATA, MEM_BUSYWAIT  memory read block and busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | port quiet, arbitrate on any request
// ISSUE | strobe presented for one cycle, memory busy ignored
// WAIT  | strobe held until memory busy drops, read data captured then
// DONE  | granted cache released for one cycle, last_grant updated
module mem_bus_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 128
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_READ,
   input  logic [ADDR_W-1:0] I_ADDRESS,
   output logic [DATA_W-1:0] I_READDATA,
   output logic              I_BUSYWAIT,
   input  logic              D_READ,
   input  logic              D_WRITE,
   input  logic [ADDR_W-1:0] D_ADDRESS,
   input  logic [DATA_W-1:0] D_WRITEDATA,
   output logic [DATA_W-1:0] D_READDATA,
   output logic              D_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   state_t            state;
   grant_t            grant;
   grant_t            last_grant;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic req_i;
   logic req_d;
   logic port_active;
   logic d_read_only;
   logic op_is_read;

   assign req_i       = I_READ;
   assign req_d       = D_READ | D_WRITE;
   assign port_active = (state == ISSUE) || (state == WAIT);
   // A D-cache request with both strobes high is treated as a write.
   assign d_read_only = D_READ & ~D_WRITE;
   // The granted requester's strobes are sampled live, so a D request that
   // drops mid-transaction stops counting as a read.
   assign op_is_read  = (grant == GNT_I) ? 1'b1 : d_read_only;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         grant      <= GNT_I;
         last_grant <= GNT_I;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i || req_d) begin
                  if (req_i && req_d)
                     grant <= (last_grant == GNT_I) ? GNT_D : GNT_I;
                  else if (req_d)
                     grant <= GNT_D;
                  else
                     grant <= GNT_I;
                  state <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (!MEM_BUSYWAIT) begin
                  state <= DONE;
                  if (op_is_read) begin
                     if (grant == GNT_I)
                        i_rdata_q <= MEM_READDATA;
                     else
                        d_rdata_q <= MEM_READDATA;
                  end
               end
            end
            DONE: begin
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      if (port_active) begin
         if (grant == GNT_I) begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = I_ADDRESS;
         end else begin
            MEM_READ      = d_read_only;
            MEM_WRITE     = D_WRITE;
            MEM_ADDRESS   = D_ADDRESS;
            MEM_WRITEDATA = D_WRITEDATA;
         end
      end
   end

   assign I_BUSYWAIT = req_i & ~((state == DONE) && (grant == GNT_I));
   assign D_BUSYWAIT = req_d & ~((state == DONE) && (grant == GNT_D));
   assign I_READDATA = i_rdata_q;
   assign D_READDATA = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
   localparam int AW = 6;
   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          I_READ;
   logic [AW-1:0] I_ADDRESS;
   logic [DW-1:0] I_READDATA;
   logic          I_BUSYWAIT;
   logic          D_READ;
   logic          D_WRITE;
   logic [AW-1:0] D_ADDRESS;
   logic [DW-1:0] D_WRITEDATA;
   logic [DW-1:0] D_READDATA;
   logic          D_BUSYWAIT;
   logic          MEM_READ;
   logic          MEM_WRITE;
   logic [AW-1:0] MEM_ADDRESS;
   logic [DW-1:0] MEM_WRITEDATA;
   logic [DW-1:0] MEM_READDATA;
   logic          MEM_BUSYWAIT;

   always #5 CLK = ~CLK;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   // Default block contents: every byte is 8'hA0 ^ address.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      logic [7:0] b;
      b = 8'hA0 ^ {2'b00, a};
      return {16{b}};
   endfunction

   // Memory behind the port: busy for busy_n cycles from the first strobe
   // cycle (or a random 0..3 in random mode), junk data while busy.
   logic [DW-1:0] mem_arr [64];
   logic [63:0]   mem_vld = '0;
   logic          mem_bw = 1'b0;
   int            mem_cnt = -1;
   int            busy_n = 0;
   bit            rand_busy = 1'b0;

   assign MEM_BUSYWAIT = mem_bw;
   assign MEM_READDATA = mem_bw ? {4{32'hDEAD_BEEF}} :
                         (mem_vld[MEM_ADDRESS] ? mem_arr[MEM_ADDRESS] : pat(MEM_ADDRESS));

   always @(posedge CLK) begin
      if (MEM_WRITE) begin
         mem_arr[MEM_ADDRESS] <= MEM_WRITEDATA;
         mem_vld[MEM_ADDRESS] <= 1'b1;
      end
   end

   always @(negedge CLK) begin
      if (!(MEM_READ || MEM_WRITE)) begin
         mem_cnt = -1;
         mem_bw  = 1'b0;
      end else begin
         if (mem_cnt < 0) mem_cnt = rand_busy ? int'($urandom_range(0, 3)) : busy_n;
         mem_bw = (mem_cnt > 0);
         if (mem_cnt > 0) mem_cnt--;
      end
   end

   // Reference memory contents as the caches should see them.
   logic [DW-1:0] ref_arr [64];
   logic [63:0]   ref_vld;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_vld[a] ? ref_arr[a] : pat(a);
   endfunction

   task automatic ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ref_arr[a] = d;
      ref_vld[a] = 1'b1;
   endtask

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   // Raise the selected requests together and serve them until each has seen
   // its BUSYWAIT drop; a request is released at the edge after completion.
   task automatic serve(input bit use_i, input logic [AW-1:0] ia,
                        input bit use_d, input bit drd, input bit dwr,
                        input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                        output logic [AW-1:0] f_addr, output logic f_rd, output logic f_wr,
                        output logic [DW-1:0] f_wd, output bit d_first,
                        output logic [DW-1:0] i_data, output logic [DW-1:0] d_data);
      bit i_done, d_done, got, i_now, d_now;
      int cyc;
      i_done = !use_i; d_done = !use_d; got = 1'b0; d_first = 1'b0; cyc = 0;
      f_addr = '0; f_rd = 1'b0; f_wr = 1'b0; f_wd = '0; i_data = '0; d_data = '0;
      tick();
      if (use_i) begin I_ADDRESS = ia; I_READ = 1'b1; end
      if (use_d) begin D_ADDRESS = da; D_WRITEDATA = dwd; D_READ = drd; D_WRITE = dwr; end
      while (!(i_done && d_done) && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         i_now = 1'b0; d_now = 1'b0;
         if (!got && (MEM_READ || MEM_WRITE)) begin
            got = 1'b1; f_addr = MEM_ADDRESS; f_rd = MEM_READ; f_wr = MEM_WRITE; f_wd = MEM_WRITEDATA;
         end
         if (!i_done && !I_BUSYWAIT) begin i_done = 1'b1; i_now = 1'b1; i_data = I_READDATA; end
         if (!d_done && !D_BUSYWAIT) begin
            d_done = 1'b1; d_now = 1'b1; d_data = D_READDATA;
            if (!i_done) d_first = 1'b1;
         end
         tick();
         if (i_now) I_READ = 1'b0;
         if (d_now) begin D_READ = 1'b0; D_WRITE = 1'b0; end
      end
      chk("serve_timeout", i_done && d_done, 1);
   endtask

   // Scoreboard for the random phase
   logic [DW-1:0] i_q[$];
   logic [DW-1:0] d_q[$];
   logic [DW-1:0] d_last;
   bit            i_fin = 1'b0;
   bit            d_fin = 1'b0;

   task automatic i_agent();
      int cyc;
      logic [AW-1:0] a;
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         a = AW'($urandom_range(0, 31));
         i_q.push_back(pat(a));
         I_ADDRESS = a;
         I_READ = 1'b1;
         cyc = 0;
         do begin @(negedge CLK); cyc++; end while (I_BUSYWAIT && cyc < 200);
         if (cyc >= 200) chk("i_agent_timeout", 0, 1);
         tick();
         I_READ = 1'b0;
      end
      i_fin = 1'b1;
   endtask

   task automatic d_agent();
      int cyc, op;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            a = AW'($urandom_range(0, 63));
            d_last = ref_rd(a);
            d_q.push_back(d_last);
            D_READ = 1'b1; D_WRITE = 1'b0;
         end else begin
            a = AW'($urandom_range(32, 63));
            wd = {$urandom, $urandom, $urandom, $urandom};
            ref_wr(a, wd);
            d_q.push_back(d_last);
            D_WRITEDATA = wd;
            D_READ = (op == 2); D_WRITE = 1'b1;
         end
         D_ADDRESS = a;
         cyc = 0;
         do begin @(negedge CLK); cyc++; end while (D_BUSYWAIT && cyc < 200);
         if (cyc >= 200) chk("d_agent_timeout", 0, 1);
         tick();
         D_READ = 1'b0; D_WRITE = 1'b0;
      end
      d_fin = 1'b1;
   endtask

   // Pops an expectation whenever a cache is released; also checks that a
   // waiting cache never sees the other one served twice ahead of it.
   task automatic monitor();
      int i_wait_d, d_wait_i;
      logic [DW-1:0] e;
      i_wait_d = 0; d_wait_i = 0;
      while (!(i_fin && d_fin)) begin
         @(negedge CLK);
         if (I_READ && !I_BUSYWAIT) begin
            if (i_q.size() == 0) chk("i_sb_empty", 0, 1);
            else begin e = i_q.pop_front(); chk("i_rdata", I_READDATA, e); end
            chk("i_fair", i_wait_d <= 1, 1);
            i_wait_d = 0;
            if (D_READ || D_WRITE) d_wait_i++;
         end
         if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
            if (d_q.size() == 0) chk("d_sb_empty", 0, 1);
            else begin e = d_q.pop_front(); chk("d_rdata", D_READDATA, e); end
            chk("d_fair", d_wait_i <= 1, 1);
            d_wait_i = 0;
            if (I_READ) i_wait_d++;
         end
      end
   endtask

   initial begin
      logic [AW-1:0] fa;
      logic          fr, fw;
      logic [DW-1:0] fwd, idat, ddat;
      bit            df;
      logic [DW-1:0] xw, yw;
      logic [3:0]    seq;
      int            n, cyc, nc;

      RESET = 1'b1;
      I_READ = 1'b0; I_ADDRESS = '0;
      D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
      ref_vld = '0;
      xw = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      yw = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_5555_AAAA;

      repeat (3) tick();
      @(negedge CLK);
      chk("rst_i_rdata", I_READDATA, '0);
      chk("rst_d_rdata", D_READDATA, '0);
      chk("rst_mem_read", MEM_READ, 0);
      chk("rst_mem_write", MEM_WRITE, 0);
      chk("rst_i_bw", I_BUSYWAIT, 0);
      tick();
      RESET = 1'b0;

      // I-cache read, slow memory; release lasts exactly one cycle
      busy_n = 5;
      tick();
      I_ADDRESS = 6'h05; I_READ = 1'b1;
      n = 0;
      do begin @(negedge CLK); n++; end while (I_BUSYWAIT && n < 60);
      chk("slow_timeout", n < 60, 1);
      chk("slow_i_rdata", I_READDATA, pat(6'h05));
      chk("slow_d_rdata", D_READDATA, '0);
      tick();
      @(negedge CLK);
      chk("i_bw_one_cycle", I_BUSYWAIT, 1);
      tick();
      I_READ = 1'b0;
      repeat (15) tick();
      chk("idle_mem_read", MEM_READ, 0);

      // First tie after reset goes to D (write), then I
      do_reset();
      busy_n = 1;
      serve(1, 6'd7, 1, 0, 1, 6'd40, xw, fa, fr, fw, fwd, df, idat, ddat);
      ref_wr(6'd40, xw);
      chk("tie1_d_first", df, 1);
      chk("tie1_mem_write", fw, 1);
      chk("tie1_addr", fa, 6'd40);
      chk("tie1_wdata", fwd, xw);
      chk("tie1_i_data", idat, pat(6'd7));

      // Next tie goes to D again since I was served last
      serve(1, 6'd8, 1, 1, 0, 6'd40, '0, fa, fr, fw, fwd, df, idat, ddat);
      chk("tie2_d_first", df, 1);
      chk("tie2_addr", fa, 6'd40);
      chk("tie2_d_data", ddat, xw);
      chk("tie2_i_data", idat, pat(6'd8));

      // D_READ and D_WRITE together: a write, D_READDATA untouched
      serve(0, '0, 1, 1, 1, 6'd41, yw, fa, fr, fw, fwd, df, idat, ddat);
      ref_wr(6'd41, yw);
      chk("both_mem_write", fw, 1);
      chk("both_mem_read", fr, 0);
      chk("both_d_keep", ddat, xw);
      serve(0, '0, 1, 1, 0, 6'd41, '0, fa, fr, fw, fwd, df, idat, ddat);
      chk("rd41_mem_read", fr, 1);
      chk("rd41_d_data", ddat, yw);

      // Reset while waiting on memory
      busy_n = 6;
      tick();
      I_ADDRESS = 6'd3; I_READ = 1'b1; D_ADDRESS = 6'd4; D_READ = 1'b1;
      cyc = 0;
      do begin @(negedge CLK); cyc++; end while (!MEM_READ && cyc < 10);
      chk("wait_strobe_seen", MEM_READ, 1);
      tick();
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("wrst_mem_read", MEM_READ, 0);
      chk("wrst_mem_write", MEM_WRITE, 0);
      chk("wrst_i_rdata", I_READDATA, '0);
      chk("wrst_d_rdata", D_READDATA, '0);
      tick();
      RESET = 1'b0; I_READ = 1'b0; D_READ = 1'b0;
      busy_n = 0;
      serve(1, 6'd10, 1, 1, 0, 6'd41, '0, fa, fr, fw, fwd, df, idat, ddat);
      chk("wrst_tie_d_first", df, 1);
      chk("wrst_tie_addr", fa, 6'd41);
      chk("wrst_tie_d_data", ddat, yw);
      chk("wrst_tie_i_data", idat, pat(6'd10));

      // Continuous requests alternate D,I,D,I
      busy_n = 2;
      tick();
      I_ADDRESS = 6'd11; I_READ = 1'b1; D_ADDRESS = 6'd12; D_READ = 1'b1;
      seq = '0; nc = 0; cyc = 0;
      while (nc < 4 && cyc < 300) begin
         @(negedge CLK);
         cyc++;
         if (!I_BUSYWAIT) begin seq = {seq[2:0], 1'b0}; nc++; end
         if (!D_BUSYWAIT) begin seq = {seq[2:0], 1'b1}; nc++; end
      end
      tick();
      I_READ = 1'b0; D_READ = 1'b0;
      chk("cont_count", nc, 4);
      chk("cont_order", seq, 4'b1010);
      chk("cont_i_data", I_READDATA, pat(6'd11));
      chk("cont_d_data", D_READDATA, pat(6'd12));

      // Zero-wait memory: released during the third edge after the request
      busy_n = 0;
      tick();
      I_ADDRESS = 6'd13; I_READ = 1'b1;
      n = 0;
      do begin @(posedge CLK); n++; @(negedge CLK); end while (I_BUSYWAIT && n < 20);
      tick();
      I_READ = 1'b0;
      chk("zero_wait_latency", n, 3);
      chk("zero_wait_data", I_READDATA, pat(6'd13));

      // Random traffic against the scoreboard
      rand_busy = 1'b1;
      d_last = pat(6'd12);
      repeat (3) tick();
      fork
         i_agent();
         d_agent();
         monitor();
      join
      chk("i_sb_drained", i_q.size(), 0);
      chk("d_sb_drained", d_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
